// File: rtl/cla_bist_pkg.sv
// Shared types, constants and helpers for the carry-lookahead adder BIST driver.
package cla_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_e;

    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED_A = 16'hACE1;
    localparam logic [15:0] DEFAULT_SEED_B = 16'h1D2C;

    // An all-zero Galois LFSR is stuck forever, so a zero seed becomes 1.
    function automatic logic [15:0] seed_fixup(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/cla_bist_if.sv
// Operand/sum boundary between the BIST driver (master) and the adder under test (slave).
interface cla_bist_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             cin;
    logic [WIDTH-1:0] sum;

    modport master (output in_a, output in_b, output cin, input sum);
    modport slave  (input in_a, input in_b, input cin, output sum);
endinterface

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous seed load and step enable.
module lfsr16
    import cla_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q <= seed_fixup(seed);
        end else if (step) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cla_bist.sv
// BIST driver/checker for the 16-bit CLA: drives LFSR vectors, waits a settle window, scores sums.
// Optional first-failure capture ports are built when CLA_BIST_LOG_EN is defined.
module cla_bist
    import cla_bist_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned NUM_TESTS     = 10,
    parameter logic [15:0] SEED_A        = DEFAULT_SEED_A,
    parameter logic [15:0] SEED_B        = DEFAULT_SEED_B,
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned CW           = $clog2(NUM_TESTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    cla_bist_if.master        adder,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     pass_count,
    output logic [CW-1:0]     fail_count
`ifdef CLA_BIST_LOG_EN
    ,
    output logic              fail_valid,
    output logic [WIDTH-1:0]  fail_a,
    output logic [WIDTH-1:0]  fail_b,
    output logic [WIDTH-1:0]  fail_sum,
    output logic              fail_cin
`endif
);

    localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [15:0] SEED_A_FIX = seed_fixup(SEED_A);
    localparam logic [15:0] SEED_B_FIX = seed_fixup(SEED_B);

    state_e           r_state;
    state_e           w_state_next;
    logic [SCW-1:0]   r_settle;
    logic [CW-1:0]    r_test_idx;
    logic [CW-1:0]    r_pass_count;
    logic [CW-1:0]    r_fail_count;
    logic [WIDTH-1:0] r_in_a;
    logic [WIDTH-1:0] r_in_b;
    logic             r_cin;

    logic [15:0]      w_lfsr_a;
    logic [15:0]      w_lfsr_b;
    logic [15:0]      w_lfsr_a_next;
    logic [15:0]      w_lfsr_b_next;
    logic             w_start_ok;
    logic             w_settle_last;
    logic             w_last_test;
    logic             w_step;
    logic [WIDTH-1:0] w_expected;
    logic             w_match;

    assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_settle_last = (r_settle == SCW'(SETTLE_CYCLES - 1));
    assign w_last_test   = (r_test_idx == CW'(NUM_TESTS - 1));
    assign w_step        = (r_state == CHECK);

    // The carry-out falls off the top; WIDTH-bit wraparound gives the truncated sum.
    assign w_expected    = r_in_a + r_in_b + WIDTH'(r_cin);
    assign w_match       = (adder.sum == w_expected);

    assign w_lfsr_a_next = lfsr_step(w_lfsr_a);
    assign w_lfsr_b_next = lfsr_step(w_lfsr_b);

    lfsr16 u_lfsr_a (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_ok),
        .seed (SEED_A),
        .step (w_step),
        .q    (w_lfsr_a)
    );

    lfsr16 u_lfsr_b (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_ok),
        .seed (SEED_B),
        .step (w_step),
        .q    (w_lfsr_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = DRIVE;
            DRIVE:   if (w_settle_last) w_state_next = CHECK;
            CHECK:   w_state_next = w_last_test ? DONE : DRIVE;
            DONE:    if (start) w_state_next = DRIVE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle     <= '0;
            r_test_idx   <= '0;
            r_pass_count <= '0;
            r_fail_count <= '0;
            r_in_a       <= '0;
            r_in_b       <= '0;
            r_cin        <= 1'b0;
        end else if (w_start_ok) begin
            r_settle     <= '0;
            r_test_idx   <= '0;
            r_pass_count <= '0;
            r_fail_count <= '0;
            r_in_a       <= WIDTH'(SEED_A_FIX);
            r_in_b       <= WIDTH'(SEED_B_FIX);
            r_cin        <= SEED_A_FIX[0] ^ SEED_B_FIX[0];
        end else if (r_state == DRIVE) begin
            r_settle <= w_settle_last ? '0 : r_settle + SCW'(1);
        end else if (r_state == CHECK) begin
            if (w_match) begin
                r_pass_count <= r_pass_count + CW'(1);
            end else begin
                r_fail_count <= r_fail_count + CW'(1);
            end
            if (!w_last_test) begin
                r_test_idx <= r_test_idx + CW'(1);
            end
            r_in_a <= WIDTH'(w_lfsr_a_next);
            r_in_b <= WIDTH'(w_lfsr_b_next);
            r_cin  <= w_lfsr_a_next[0] ^ w_lfsr_b_next[0];
        end
    end

`ifdef CLA_BIST_LOG_EN
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [WIDTH-1:0] r_fail_sum;
    logic             r_fail_cin;

    // Only the first mismatch of a run is kept; later ones leave the record alone.
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_sum   <= '0;
            r_fail_cin   <= 1'b0;
        end else if ((r_state == CHECK) && !w_match && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_a     <= r_in_a;
            r_fail_b     <= r_in_b;
            r_fail_sum   <= adder.sum;
            r_fail_cin   <= r_cin;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;
    assign fail_sum   = r_fail_sum;
    assign fail_cin   = r_fail_cin;
`endif

    assign adder.in_a = r_in_a;
    assign adder.in_b = r_in_b;
    assign adder.cin  = r_cin;
    assign busy       = (r_state == DRIVE) || (r_state == CHECK);
    assign done       = (r_state == DONE);
    assign pass_count = r_pass_count;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_cla_bist.sv
// Scoreboard bench for cla_bist: the bench plays the adder (with selectable faults) and predicts vectors and scores.
module tb_cla_bist;

    localparam int unsigned W  = 16;
    localparam int unsigned NT = 10;
    localparam int unsigned SC = 1;
    localparam int unsigned CW = $clog2(NT + 1);

    typedef struct {
        int          p;
        int          f;
        bit          fv;
        logic [15:0] fa;
        logic [15:0] fb;
        logic [15:0] fs;
        logic        fc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_z = 1'b0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [32:0] vq[$];
    logic [32:0] vqz[$];
    res_t        rq[$];

    int          adder_mode = 0;
    logic [15:0] flt_a = '0;
    logic [15:0] flt_b = '0;
    logic        flt_c = 1'b0;

    cla_bist_if #(.WIDTH(W)) bus ();
    cla_bist_if #(.WIDTH(W)) bus_z ();

    logic          busy, done, busy_z, done_z;
    logic [CW-1:0] pass_count, fail_count, pass_z, fail_z;
`ifdef CLA_BIST_LOG_EN
    logic          fail_valid, fail_cin, fv_z, fc_z;
    logic [W-1:0]  fail_a, fail_b, fail_sum, fa_z, fb_z, fs_z;
`endif

    function automatic logic [15:0] tb_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // Behaviour of the adder the bench presents to the DUT.
    function automatic logic [15:0] adder_fn(input int mode, input logic [15:0] a,
                                             input logic [15:0] b, input logic c, input bit hit);
        logic [15:0] s;
        s = a + b + {15'd0, c};
        case (mode)
            1: s[0] = 1'b0;
            2: if (hit) s = s ^ 16'h0100;
            3: s[15] = 1'b0;
            default: ;
        endcase
        return s;
    endfunction

    assign bus.sum = adder_fn(adder_mode, bus.in_a, bus.in_b, bus.cin,
                              {bus.in_a, bus.in_b, bus.cin} == {flt_a, flt_b, flt_c});
    assign bus_z.sum = bus_z.in_a + bus_z.in_b + {15'd0, bus_z.cin};

    cla_bist #(
        .WIDTH         (W),
        .NUM_TESTS     (NT),
        .SEED_A        (16'hACE1),
        .SEED_B        (16'h1D2C),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .adder      (bus),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count),
        .fail_count (fail_count)
`ifdef CLA_BIST_LOG_EN
        ,
        .fail_valid (fail_valid),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_sum   (fail_sum),
        .fail_cin   (fail_cin)
`endif
    );

    cla_bist #(
        .WIDTH         (W),
        .NUM_TESTS     (NT),
        .SEED_A        (16'h0000),
        .SEED_B        (16'h1D2C),
        .SETTLE_CYCLES (SC)
    ) dut_z (
        .clk        (clk),
        .rst        (rst),
        .start      (start_z),
        .adder      (bus_z),
        .busy       (busy_z),
        .done       (done_z),
        .pass_count (pass_z),
        .fail_count (fail_z)
`ifdef CLA_BIST_LOG_EN
        ,
        .fail_valid (fv_z),
        .fail_a     (fa_z),
        .fail_b     (fb_z),
        .fail_sum   (fs_z),
        .fail_cin   (fc_z)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Vector monitor: each new vector presented while busy is popped and compared.
    logic        prev_busy = 1'b0;
    logic [32:0] prev_vec = '0;
    logic        prev_done = 1'b0;
    logic        prev_busy_z = 1'b0;
    logic [32:0] prev_vec_z = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        logic [32:0] cur;
        cur = {bus.in_a, bus.in_b, bus.cin};
        if (busy && (!prev_busy || cur != prev_vec)) begin
            if (vq.size() == 0) begin
                chk("vec_unexpected", 32'd1, 32'd0);
            end else begin
                e = vq.pop_front();
                chk("vec_in_a", {16'd0, bus.in_a}, {16'd0, e[32:17]});
                chk("vec_in_b", {16'd0, bus.in_b}, {16'd0, e[16:1]});
                chk("vec_cin", {31'd0, bus.cin}, {31'd0, e[0]});
            end
        end
        prev_busy <= busy;
        prev_vec  <= cur;
    end

    // Result monitor: every rising edge of done consumes one predicted outcome.
    always @(negedge clk) begin
        res_t r;
        if (done && !prev_done) begin
            if (rq.size() == 0) begin
                chk("result_unexpected", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("pass_count", {28'd0, pass_count}, r.p);
                chk("fail_count", {28'd0, fail_count}, r.f);
                chk("count_sum", {28'd0, pass_count} + {28'd0, fail_count}, NT);
`ifdef CLA_BIST_LOG_EN
                chk("fail_valid", {31'd0, fail_valid}, {31'd0, r.fv});
                chk("fail_a", {16'd0, fail_a}, {16'd0, r.fa});
                chk("fail_b", {16'd0, fail_b}, {16'd0, r.fb});
                chk("fail_sum", {16'd0, fail_sum}, {16'd0, r.fs});
                chk("fail_cin", {31'd0, fail_cin}, {31'd0, r.fc});
`endif
            end
        end
        prev_done <= done;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        logic [32:0] cur;
        cur = {bus_z.in_a, bus_z.in_b, bus_z.cin};
        if (busy_z && (!prev_busy_z || cur != prev_vec_z)) begin
            chk("z_in_a_nonzero", {31'd0, bus_z.in_a != 16'h0000}, 32'd1);
            if (vqz.size() == 0) begin
                chk("z_vec_unexpected", 32'd1, 32'd0);
            end else begin
                e = vqz.pop_front();
                chk("z_vec", {31'd0, cur == e}, 32'd1);
            end
        end
        prev_busy_z <= busy_z;
        prev_vec_z  <= cur;
    end

    task automatic predict(input int mode, input int nvec, input bit push_res);
        logic [15:0] a, b, se, sg;
        logic        c;
        res_t        r;
        r = '{p: 0, f: 0, fv: 1'b0, fa: '0, fb: '0, fs: '0, fc: 1'b0};
        a = 16'hACE1;
        b = 16'h1D2C;
        for (int i = 0; i < NT; i++) begin
            c = a[0] ^ b[0];
            if (i < nvec) vq.push_back({a, b, c});
            if (i == 2) begin
                flt_a = a;
                flt_b = b;
                flt_c = c;
            end
            se = a + b + {15'd0, c};
            sg = adder_fn(mode, a, b, c, i == 2);
            if (sg == se) begin
                r.p++;
            end else begin
                r.f++;
                if (!r.fv) begin
                    r.fv = 1'b1;
                    r.fa = a;
                    r.fb = b;
                    r.fs = sg;
                    r.fc = c;
                end
            end
            a = tb_step(a);
            b = tb_step(b);
        end
        if (push_res) rq.push_back(r);
    endtask

    task automatic run(input int mode, input bit poke);
        int n;
        adder_mode = mode;
        predict(mode, NT, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_clears_pass", {28'd0, pass_count}, 32'd0);
        chk("start_clears_fail", {28'd0, fail_count}, 32'd0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
            start = poke && (n == 5);
        end
        start = 1'b0;
        chk("run_done", {31'd0, done}, 32'd1);
        chk("run_cycles", n, NT * (SC + 1));
    endtask

    initial begin
        logic [15:0] a, b;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {28'd0, pass_count}, 32'd0);
        chk("rst_fail", {28'd0, fail_count}, 32'd0);
        chk("rst_in_a", {16'd0, bus.in_a}, 32'd0);
        chk("rst_in_b", {16'd0, bus.in_b}, 32'd0);
        chk("rst_cin", {31'd0, bus.cin}, 32'd0);
        rst = 1'b0;

        run(0, 1'b0);
        // Restart from DONE with a stray start mid-run: same sequence, same length.
        run(0, 1'b1);
        run(1, 1'b0);
        run(3, 1'b0);

        // Abort during vector 5.
        adder_mode = 0;
        predict(0, 5, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_pass", {28'd0, pass_count}, 32'd0);
        chk("abort_fail", {28'd0, fail_count}, 32'd0);
        chk("abort_in_a", {16'd0, bus.in_a}, 32'd0);
        chk("abort_in_b", {16'd0, bus.in_b}, 32'd0);
        chk("abort_cin", {31'd0, bus.cin}, 32'd0);
        run(0, 1'b0);

`ifdef CLA_BIST_LOG_EN
        run(2, 1'b0);
`endif

        // Zero seed for operand A is replaced by 1.
        a = 16'h0001;
        b = 16'h1D2C;
        for (int i = 0; i < NT; i++) begin
            vqz.push_back({a, b, a[0] ^ b[0]});
            a = tb_step(a);
            b = tb_step(b);
        end
        @(negedge clk);
        start_z = 1'b1;
        @(posedge clk);
        #1 start_z = 1'b0;
        chk("z_first_in_a", {16'd0, bus_z.in_a}, 32'h0001);
        n = 0;
        while (!done_z && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("z_done", {31'd0, done_z}, 32'd1);
        chk("z_pass", {28'd0, pass_z}, NT);
        chk("z_fail", {28'd0, fail_z}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("vq_drained", vq.size(), 32'd0);
        chk("rq_drained", rq.size(), 32'd0);
        chk("vqz_drained", vqz.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
